// File: rtl/rng_arbiter.sv
// rtl/rng_arbiter.sv - round-robin arbiter sharing one free-running rng word source
// Warms the generator up after reset/rewarm, then hands each fresh word to exactly one requester.
module rng_arbiter #(
  parameter int N_REQ  = 4,
  parameter int WIDTH  = 32,
  parameter int WARMUP = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rewarm,
  output logic             rng_step,
  input  logic [WIDTH-1:0] rng_word,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [WIDTH-1:0] rnd_out,
  output logic             rnd_valid,
  output logic             warm_done
);

  localparam int            PW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int            CW        = $clog2(WARMUP) + 1;
  localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(N_REQ - 1);

  typedef enum logic {WARM, SERVE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    warm_cnt, warm_cnt_nxt;
  logic [PW-1:0]    ptr, ptr_nxt, pick;
  logic [N_REQ-1:0] elig, gnt_nxt;
  logic             found, grant;

  // The requester holding gnt this cycle is masked so a held req cannot take two words in a row.
  assign elig = req & ~gnt;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && elig[(int'(ptr) + i) % N_REQ]) begin
        found = 1'b1;
        pick  = PW'((int'(ptr) + i) % N_REQ);
      end
    end
  end

  assign grant     = (state == SERVE) && !rewarm && found;
  assign rng_step  = !reset && ((state == WARM) || grant);
  assign warm_done = (state == SERVE);

  always_comb begin
    state_nxt    = state;
    warm_cnt_nxt = warm_cnt;
    ptr_nxt      = ptr;
    gnt_nxt      = '0;
    case (state)
      WARM: begin
        if (rewarm) begin
          warm_cnt_nxt = '0;
        end else if (warm_cnt == WARM_LAST) begin
          state_nxt    = SERVE;
          warm_cnt_nxt = '0;
        end else begin
          warm_cnt_nxt = warm_cnt + CW'(1);
        end
      end
      SERVE: begin
        if (rewarm) begin
          state_nxt    = WARM;
          warm_cnt_nxt = '0;
        end else if (grant) begin
          gnt_nxt = N_REQ'(1) << pick;
          ptr_nxt = (pick == PTR_LAST) ? '0 : pick + PW'(1);
        end
      end
      default: state_nxt = WARM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= WARM;
      warm_cnt  <= '0;
      ptr       <= '0;
      gnt       <= '0;
      rnd_out   <= '0;
      rnd_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      warm_cnt  <= warm_cnt_nxt;
      ptr       <= ptr_nxt;
      gnt       <= gnt_nxt;
      rnd_valid <= grant;
      if (grant) rnd_out <= rng_word;
    end
  end

endmodule
